// File: rtl/vadd_seq_ctrl.sv
// Sequencer for the lane-split vector add/sub datapath.
// Streams VRF beats through the external adder and writes packed results back.
module vadd_seq_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int VL_WIDTH    = 11,
  parameter int OPSEL_WIDTH = 5,
  parameter int SEW_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPSEL_WIDTH-1:0] req_opsel,
  input  logic [SEW_WIDTH-1:0]   req_sew,
  input  logic                   req_carry,
  input  logic [VL_WIDTH-1:0]    req_vl,
  input  logic [ADDR_WIDTH-1:0]  req_vs1,
  input  logic [ADDR_WIDTH-1:0]  req_vs2,
  input  logic [ADDR_WIDTH-1:0]  req_vd,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr0,
  output logic [ADDR_WIDTH-1:0]  rd_addr1,
  input  logic [63:0]            rd_data0,
  input  logic [63:0]            rd_data1,
  output logic [63:0]            add_vec0,
  output logic [63:0]            add_vec1,
  output logic [SEW_WIDTH-1:0]   add_sew,
  output logic [OPSEL_WIDTH-1:0] add_opsel,
  output logic                   add_carry,
  input  logic [80:0]            add_result,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [63:0]            wr_data,
  output logic [7:0]             wr_be,
  output logic                   busy,
  output logic                   done
);

  localparam int NB_W = VL_WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [VL_WIDTH-1:0]   k;
  logic [VL_WIDTH-1:0]   last_k;
  logic [7:0]            last_be;
  logic [ADDR_WIDTH-1:0] vs1_q;
  logic [ADDR_WIDTH-1:0] vs2_q;
  logic [ADDR_WIDTH-1:0] vd_q;

  logic                  d_valid;
  logic                  d_last;
  logic [ADDR_WIDTH-1:0] d_k;

  logic                  wr_last;

  logic                  accept;
  logic                  k_last;
  logic [NB_W-1:0]       nbytes;
  logic [NB_W-1:0]       nbytes_up;
  logic [VL_WIDTH-1:0]   nbeats;
  logic [7:0]            be_tail;
  logic [63:0]           packed_res;
  logic [16:0]           guard_bits;
  logic                  unused_guard;

  assign accept = req_valid && (state == S_IDLE);
  assign k_last = (k == last_k);

  // Byte count fits NB_W bits even at max VL and SEW=64b, so +7 cannot overflow.
  assign nbytes    = {3'b000, req_vl} << req_sew;
  assign nbytes_up = nbytes + NB_W'(7);
  assign nbeats    = nbytes_up[NB_W-1:3];

  always_comb begin
    be_tail = 8'hFF;
    unique case (nbytes[2:0])
      3'd1:    be_tail = 8'h01;
      3'd2:    be_tail = 8'h03;
      3'd3:    be_tail = 8'h07;
      3'd4:    be_tail = 8'h0F;
      3'd5:    be_tail = 8'h1F;
      3'd6:    be_tail = 8'h3F;
      3'd7:    be_tail = 8'h7F;
      default: be_tail = 8'hFF;
    endcase
  end

  // Each 10-bit adder lane carries a guard bit on both sides of its byte.
  for (genvar i = 0; i < 8; i++) begin : g_pack
    assign packed_res[8*i +: 8]  = add_result[10*i+1 +: 8];
    assign guard_bits[2*i]       = add_result[10*i];
    assign guard_bits[2*i+1]     = add_result[10*i+9];
  end
  assign guard_bits[16] = add_result[80];
  assign unused_guard   = ^guard_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          if (accept) begin
            state <= (req_vl == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (k_last) begin
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr_en && wr_last) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_opsel <= '0;
      add_sew   <= '0;
      add_carry <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      last_k    <= '0;
      last_be   <= 8'hFF;
    end else if (accept) begin
      add_opsel <= req_opsel;
      add_sew   <= req_sew;
      add_carry <= req_carry;
      vs1_q     <= req_vs1;
      vs2_q     <= req_vs2;
      vd_q      <= req_vd;
      last_k    <= nbeats - 1'b1;
      last_be   <= be_tail;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign rd_en     = (state == S_RUN);

  assign rd_addr0 = rd_en ? vs1_q + k[ADDR_WIDTH-1:0] : '0;
  assign rd_addr1 = rd_en ? vs2_q + k[ADDR_WIDTH-1:0] : '0;

  // Data cycle: VRF returns the beat read in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_last  <= 1'b0;
      d_k     <= '0;
    end else begin
      d_valid <= rd_en;
      d_last  <= rd_en && k_last;
      d_k     <= k[ADDR_WIDTH-1:0];
    end
  end

  assign add_vec0 = d_valid ? rd_data0 : '0;
  assign add_vec1 = d_valid ? rd_data1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_last <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
    end else begin
      wr_en   <= d_valid;
      wr_last <= d_valid && d_last;
      if (d_valid) begin
        wr_addr <= vd_q + d_k;
        wr_data <= packed_res;
        wr_be   <= d_last ? last_be : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// Self-checking bench for vadd_seq_ctrl.
// VRF and lane adder are modelled here; writes are scored against element math.
module tb_vadd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opsel;
  logic [1:0]  req_sew;
  logic        req_carry;
  logic [10:0] req_vl;
  logic [4:0]  req_vs1, req_vs2, req_vd;
  logic        rd_en;
  logic [4:0]  rd_addr0, rd_addr1;
  logic [63:0] rd_data0, rd_data1;
  logic [63:0] add_vec0, add_vec1;
  logic [1:0]  add_sew;
  logic [4:0]  add_opsel;
  logic        add_carry;
  logic [80:0] add_result;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        busy, done;

  vadd_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opsel(req_opsel), .req_sew(req_sew),
    .req_carry(req_carry), .req_vl(req_vl),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .add_vec0(add_vec0), .add_vec1(add_vec1),
    .add_sew(add_sew), .add_opsel(add_opsel),
    .add_carry(add_carry), .add_result(add_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [63:0] mem0 [32];
  logic [63:0] mem1 [32];
  logic [80:0] guard;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    guard <= 81'({$urandom, $urandom, $urandom});
    if (rd_en) begin
      rd_data0 <= mem0[rd_addr0];
      rd_data1 <= mem1[rd_addr1];
    end else begin
      rd_data0 <= {$urandom, $urandom};
      rd_data1 <= {$urandom, $urandom};
    end
  end

  // Element-wise add/sub at the given SEW.
  function automatic logic [63:0] elem(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] sew, input logic sub,
                                       input logic cin);
    int w;
    logic [63:0] m, ea, eb, r, res;
    w   = 8 << sew;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int e = 0; e < 64 / w; e++) begin
      ea  = (a >> (e * w)) & m;
      eb  = (b >> (e * w)) & m;
      r   = sub ? ea - eb - 64'(cin) : ea + eb + 64'(cin);
      res = res | ((r & m) << (e * w));
    end
    return res;
  endfunction

  // Lane-split result format: byte i at [10i+8:10i+1], everything else guard.
  function automatic logic [80:0] spread(input logic [63:0] r, input logic [80:0] g);
    logic [80:0] res;
    res = g;
    for (int i = 0; i < 8; i++) res[10*i+1 +: 8] = r[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    add_result = spread(elem(add_vec0, add_vec1, add_sew, add_opsel[1], add_carry), guard);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic scramble();
    req_valid = 1'b1;
    req_opsel = 5'($urandom);
    req_sew   = 2'($urandom);
    req_carry = 1'($urandom);
    req_vl    = 11'($urandom);
    req_vs1   = 5'($urandom);
    req_vs2   = 5'($urandom);
    req_vd    = 5'($urandom);
  endtask

  task automatic run_op(input logic [4:0] opsel, input logic [1:0] sew,
                        input logic carry, input logic [10:0] vl,
                        input logic [4:0] vs1, input logic [4:0] vs2,
                        input logic [4:0] vd, input bit junk,
                        output int lat, output int nwr,
                        output logic [7:0] lbe, output logic [63:0] ldata);
    int n, nbytes, lastbytes, rdc, gc, c0;
    bit addr_bad, vec_bad, prev_rd;
    logic [4:0] ea0, ea1;
    logic [63:0] ev0, ev1, exp_d;
    logic [7:0] exp_be;
    logic [4:0] qa[$];
    logic [63:0] qd[$];
    logic [7:0] qb[$];
    nbytes = int'(vl) << sew;
    n = (nbytes + 7) / 8;
    lastbytes = nbytes - 8 * (n - 1);
    rdc = 0; addr_bad = 0; vec_bad = 0; prev_rd = 0;
    lat = -1;
    gc = 0;
    @(negedge clk);
    while (!req_ready && gc < 100) begin
      @(negedge clk);
      gc++;
    end
    req_valid = 1'b1; req_opsel = opsel; req_sew = sew; req_carry = carry;
    req_vl = vl; req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (junk && t > 0) scramble();
      if (rd_en) begin
        ea0 = vs1 + 5'(rdc);
        ea1 = vs2 + 5'(rdc);
        if (rd_addr0 !== ea0 || rd_addr1 !== ea1) addr_bad = 1;
        rdc++;
      end
      ev0 = prev_rd ? rd_data0 : 64'd0;
      ev1 = prev_rd ? rd_data1 : 64'd0;
      if (add_vec0 !== ev0 || add_vec1 !== ev1) vec_bad = 1;
      prev_rd = rd_en;
      if (wr_en) begin
        qa.push_back(wr_addr);
        qd.push_back(wr_data);
        qb.push_back(wr_be);
      end
      if (done) begin
        lat = cyc - c0;
        req_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("done_timeout", 64'(lat), 64'(n + 3));
    chk("done_latency", 64'(lat), (n == 0) ? 64'd1 : 64'(n + 3));
    chk("rd_count", 64'(rdc), 64'(n));
    chk("wr_count", 64'(qa.size()), 64'(n));
    chk("rd_addr", 64'(addr_bad), 64'd0);
    chk("vec_gate", 64'(vec_bad), 64'd0);
    for (int k = 0; k < n && k < qa.size(); k++) begin
      ea0 = vs1 + 5'(k);
      ea1 = vs2 + 5'(k);
      exp_d = elem(mem0[ea0], mem1[ea1], sew, opsel[1], carry);
      exp_be = (k == n - 1) ? 8'((9'd1 << lastbytes) - 9'd1) : 8'hFF;
      chk("wr_addr", 64'(qa[k]), 64'(5'(vd + 5'(k))));
      chk("wr_data", qd[k], exp_d);
      chk("wr_be", 64'(qb[k]), 64'(exp_be));
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("after_done", 64'({req_ready, done, busy}), 64'(3'b100));
    nwr = qa.size();
    lbe = (nwr > 0) ? qb[nwr-1] : 8'h00;
    ldata = (nwr > 0) ? qd[nwr-1] : 64'h0;
  endtask

  typedef struct {
    logic [4:0]  opsel;
    logic [1:0]  sew;
    logic        carry;
    logic [10:0] vl;
    logic [4:0]  vs1, vs2, vd;
    int          exp_lat;
    int          exp_nwr;
    logic [7:0]  exp_lbe;
    bit          has_data;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat, nwr, bad;
    logic [7:0] lbe;
    logic [63:0] ldata;

    tbl[0] = '{5'd0, 2'd0, 1'b0, 11'd8, 5'd0, 5'd1, 5'd2,
               4, 1, 8'hFF, 1'b1, 64'h0203040506070809};
    tbl[1] = '{5'd0, 2'd2, 1'b0, 11'd3, 5'd6, 5'd7, 5'd30,
               5, 2, 8'h0F, 1'b0, 64'h0};
    tbl[2] = '{5'd0, 2'd1, 1'b0, 11'd5, 5'd10, 5'd12, 5'd31,
               5, 2, 8'h03, 1'b0, 64'h0};
    tbl[3] = '{5'd0, 2'd0, 1'b0, 11'd0, 5'd3, 5'd3, 5'd3,
               1, 0, 8'h00, 1'b0, 64'h0};
    tbl[4] = '{5'd2, 2'd3, 1'b0, 11'd1, 5'd4, 5'd5, 5'd9,
               4, 1, 8'hFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{5'd0, 2'd0, 1'b1, 11'd13, 5'd20, 5'd22, 5'd14,
               5, 2, 8'h1F, 1'b0, 64'h0};

    for (int i = 0; i < 32; i++) begin
      mem0[i] = {$urandom, $urandom};
      mem1[i] = {$urandom, $urandom};
    end
    mem0[0] = 64'h0102030405060708;
    mem1[1] = 64'h0101010101010101;
    mem0[4] = 64'h0;
    mem1[5] = 64'h1;

    rst = 1'b1;
    req_valid = 1'b0; req_opsel = '0; req_sew = '0; req_carry = 1'b0;
    req_vl = '0; req_vs1 = '0; req_vs2 = '0; req_vd = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({req_ready, rd_en, wr_en, busy, done}), 64'(5'b10000));
    chk("reset_data", 64'({wr_data, wr_be, wr_addr, rd_addr0, rd_addr1} != 0), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].opsel, tbl[i].sew, tbl[i].carry, tbl[i].vl,
             tbl[i].vs1, tbl[i].vs2, tbl[i].vd, 1'b0, lat, nwr, lbe, ldata);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_nwr", i), 64'(nwr), 64'(tbl[i].exp_nwr));
      chk($sformatf("tbl%0d_lbe", i), 64'(lbe), 64'(tbl[i].exp_lbe));
      if (tbl[i].has_data) chk($sformatf("tbl%0d_data", i), ldata, tbl[i].exp_data);
    end

    // Reset in the middle of a long op.
    @(negedge clk);
    req_valid = 1'b1; req_opsel = 5'd0; req_sew = 2'd3; req_carry = 1'b0;
    req_vl = 11'd32; req_vs1 = 5'd0; req_vs2 = 5'd8; req_vd = 5'd16;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 64'({req_ready, busy, done, rd_en, wr_en}), 64'(5'b10000));
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (wr_en || done || rd_en || !req_ready) bad++;
    end
    chk("mid_rst_quiet", 64'(bad), 64'd0);
    run_op(5'd0, 2'd3, 1'b1, 11'd4, 5'd2, 5'd28, 5'd29, 1'b1, lat, nwr, lbe, ldata);
    chk("post_rst_nwr", 64'(nwr), 64'd4);

    // Randomized ops with garbage on the request bus while busy.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] = {$urandom, $urandom};
        mem1[i] = {$urandom, $urandom};
      end
      run_op(5'($urandom), 2'($urandom), 1'($urandom),
             11'($urandom_range(0, 40)), 5'($urandom), 5'($urandom),
             5'($urandom), 1'($urandom), lat, nwr, lbe, ldata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
